// File: rtl/frame_rect_renderer_if.sv
// frame_rect_renderer_if
//   AXI4-Stream style pixel output bundle for frame_rect_renderer.
//   master modport: the renderer drives valid/last/data and samples ready.
//   slave modport : the downstream sink drives ready.
//   Signals:
//     m_axis_tvalid  pixel valid
//     m_axis_tready  sink ready
//     m_axis_tlast   final pixel of the frame
//     m_axis_tdata   RGB565 pixel
interface frame_rect_renderer_if;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] m_axis_tdata;

  modport master (
    output m_axis_tvalid,
    output m_axis_tlast,
    output m_axis_tdata,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  m_axis_tdata,
    output m_axis_tready
  );
endinterface

// File: rtl/frame_rect_renderer.sv
// frame_rect_renderer
//   Streams one FRAME_W x FRAME_H RGB565 frame per frame_start, raster order.
//   Each pixel takes the colour of the lowest-index enabled rectangle covering
//   it, else BG_COLOR. Rectangles are written into shadow slots at any time
//   and latched into active slots when a frame starts, so a frame never sees
//   a partial update.
//   Ports:
//     aclk, reset          clock, synchronous active-high reset
//     frame_start          request one frame (honoured only when idle)
//     cfg_we/cfg_idx       shadow slot write strobe and slot index
//     cfg_x0/x1/y0/y1      rectangle, start inclusive, end exclusive
//     cfg_color, cfg_en    fill colour and slot enable
//     busy                 frame in progress
//     frame_done           one-cycle pulse after the last pixel handshake
//     axis                 pixel stream (master side)
module frame_rect_renderer #(
  parameter int          FRAME_W  = 320,
  parameter int          FRAME_H  = 240,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [8:0]  cfg_x0,
  input  logic [8:0]  cfg_x1,
  input  logic [8:0]  cfg_y0,
  input  logic [8:0]  cfg_y1,
  input  logic [15:0] cfg_color,
  input  logic        cfg_en,
  output logic        busy,
  output logic        frame_done,
  frame_rect_renderer_if.master axis
);

  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [8:0] X_LAST = 9'(FRAME_W - 1);
  localparam logic [8:0] Y_LAST = 9'(FRAME_H - 1);

  typedef struct packed {
    logic        en;
    logic [8:0]  x0;
    logic [8:0]  x1;
    logic [8:0]  y0;
    logic [8:0]  y1;
    logic [15:0] color;
  } rect_t;

  rect_t [NUM_SLOTS-1:0] shadow_q;
  rect_t [NUM_SLOTS-1:0] active_q;

  logic [1:0]  state_q;
  logic [8:0]  x_q, y_q;
  logic        tvalid_q, tlast_q, frame_done_q;
  logic [15:0] tdata_q;

  logic [NUM_SLOTS-1:0] hit;
  logic [15:0]          pix_color;
  logic                 pix_fire;
  logic                 pix_last;

  // Degenerate rectangles (x1<=x0 or y1<=y0) fall out of the half-open
  // compares naturally; out-of-frame extents simply never reach the counters.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
    assign hit[g] = active_q[g].en &&
                    (x_q >= active_q[g].x0) && (x_q < active_q[g].x1) &&
                    (y_q >= active_q[g].y0) && (y_q < active_q[g].y1);
  end

  // Walk from the highest slot down so the lowest matching index wins.
  always_comb begin
    pix_color = BG_COLOR;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) pix_color = active_q[i].color;
    end
  end

  // Output register is refilled whenever it is empty or being consumed.
  assign pix_fire = (state_q == ST_RUN) && (!tvalid_q || axis.m_axis_tready);
  assign pix_last = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      frame_done_q <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
    end else begin
      frame_done_q <= 1'b0;

      // Shadow write; a same-edge copy below reads the old shadow contents.
      if (cfg_we)
        shadow_q[cfg_idx] <= {cfg_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_color};

      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            active_q <= shadow_q;
            x_q      <= '0;
            y_q      <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pix_fire) begin
            tdata_q  <= pix_color;
            tvalid_q <= 1'b1;
            tlast_q  <= pix_last;
            if (pix_last) begin
              state_q <= ST_DRAIN;
            end else if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + 9'd1;
            end else begin
              x_q <= x_q + 9'd1;
            end
          end
        end
        ST_DRAIN: begin
          // Last pixel is parked in the output register until accepted.
          if (tvalid_q && axis.m_axis_tready) begin
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy               = (state_q != ST_IDLE);
  assign frame_done         = frame_done_q;
  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tlast  = tlast_q;
  assign axis.m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_frame_rect_renderer.sv
// tb_frame_rect_renderer
//   Drives frame_rect_renderer on a reduced 64x48 frame, captures every pixel
//   handshake and compares whole frames against a rectangle-list model, plus
//   tables of spot pixels and hand-written reset/latency/backpressure cases.
module tb_frame_rect_renderer;
  localparam int W    = 64;
  localparam int H    = 48;
  localparam int NPIX = W * H;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [8:0]  cfg_x0 = '0, cfg_x1 = '0, cfg_y0 = '0, cfg_y1 = '0;
  logic [15:0] cfg_color = '0;
  logic        cfg_en = 1'b0;
  logic        busy, frame_done;

  frame_rect_renderer_if axis_if ();

  frame_rect_renderer #(.FRAME_W(W), .FRAME_H(H), .BG_COLOR(16'h0000)) dut (
    .aclk        (aclk),
    .reset       (reset),
    .frame_start (frame_start),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_x0      (cfg_x0),
    .cfg_x1      (cfg_x1),
    .cfg_y0      (cfg_y0),
    .cfg_y1      (cfg_y1),
    .cfg_color   (cfg_color),
    .cfg_en      (cfg_en),
    .busy        (busy),
    .frame_done  (frame_done),
    .axis        (axis_if)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          en;
    int          x0, x1, y0, y1;
    logic [15:0] color;
  } slot_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } pix_t;

  typedef struct {
    int          x, y;
    logic [15:0] exp;
  } probe_t;

  slot_t sh_m[4];
  slot_t act_m[4];
  pix_t  got[$];

  int checks = 0, errors = 0;
  int cyc = 0, hs_cyc = 0, fd_cyc = 0, fd_cnt = 0, fd_base = 0;
  bit mon_en = 0, bp_en = 0;
  bit prev_stall = 0;
  logic [15:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Spec rule: first enabled slot (lowest index) whose half-open box covers
  // the pixel supplies the colour; anything else is background.
  function automatic logic [15:0] ref_color(input int x, input int y);
    for (int i = 0; i < 4; i++)
      if (act_m[i].en && x >= act_m[i].x0 && x < act_m[i].x1 &&
          y >= act_m[i].y0 && y < act_m[i].y1)
        return act_m[i].color;
    return 16'h0000;
  endfunction

  // Sink readiness: always ready, or randomly stalling about a third of cycles.
  initial axis_if.m_axis_tready = 1'b1;
  always begin
    @(posedge aclk);
    #1;
    axis_if.m_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor samples mid-cycle; tvalid&&tready here means a handshake at the
  // next rising edge.
  always @(negedge aclk) begin
    cyc++;
    if (mon_en) begin
      if (prev_stall) begin
        checks++;
        if (!(axis_if.m_axis_tvalid && axis_if.m_axis_tdata === prev_data &&
              axis_if.m_axis_tlast === prev_last)) begin
          errors++;
          $display("FAIL stall_hold actual=%0b/%0h/%0b expected=1/%0h/%0b",
                   axis_if.m_axis_tvalid, axis_if.m_axis_tdata, axis_if.m_axis_tlast,
                   prev_data, prev_last);
        end
      end
      if (axis_if.m_axis_tvalid && axis_if.m_axis_tready) begin
        got.push_back('{axis_if.m_axis_tdata, axis_if.m_axis_tlast});
        hs_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
    prev_stall = mon_en && axis_if.m_axis_tvalid && !axis_if.m_axis_tready;
    prev_data  = axis_if.m_axis_tdata;
    prev_last  = axis_if.m_axis_tlast;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    frame_start = 1'b0;
    cfg_we      = 1'b0;
  endtask

  task automatic start_frame();
    act_m       = sh_m;
    got.delete();
    fd_base     = fd_cnt;
    frame_start = 1'b1;
    tick();
  endtask

  // Writes a shadow slot; with_start also launches a frame on the same edge,
  // which must latch the pre-write slot contents.
  task automatic write_slot(input int idx, input int x0, input int x1, input int y0,
                            input int y1, input logic [15:0] color, input bit en,
                            input bit with_start);
    cfg_idx   = 2'(idx);
    cfg_x0    = 9'(x0);
    cfg_x1    = 9'(x1);
    cfg_y0    = 9'(y0);
    cfg_y1    = 9'(y1);
    cfg_color = color;
    cfg_en    = en;
    cfg_we    = 1'b1;
    if (with_start) begin
      act_m       = sh_m;
      got.delete();
      fd_base     = fd_cnt;
      frame_start = 1'b1;
    end
    sh_m[idx] = '{en, x0, x1, y0, y1, color};
    tick();
  endtask

  task automatic wait_pixels(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 8 * NPIX) begin
      tick();
      k++;
    end
    chk({tag, "_reach"}, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic finish_frame(input string tag);
    int k = 0, mism = 0, nlast = 0, first_bad = -1;
    while (fd_cnt == fd_base && k < 8 * NPIX) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(fd_cnt > fd_base), 32'd1);
    repeat (3) tick();
    chk({tag, "_done_pulses"}, 32'(fd_cnt - fd_base), 32'd1);
    chk({tag, "_handshakes"}, 32'(got.size()), 32'(NPIX));
    foreach (got[i]) begin
      if (got[i].last) nlast++;
      if (got[i].data !== ref_color(i % W, i / W) || got[i].last !== (i == NPIX - 1)) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (first_bad >= 0)
      $display("note %s first bad pixel %0d got %0h last=%0b want %0h", tag, first_bad,
               got[first_bad].data, got[first_bad].last,
               ref_color(first_bad % W, first_bad / W));
    chk({tag, "_pixel_mismatches"}, 32'(mism), 32'd0);
    chk({tag, "_tlast_count"}, 32'(nlast), 32'd1);
    chk({tag, "_done_after_last"}, 32'(fd_cyc - hs_cyc), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run_probes(input string tag, input probe_t pr[]);
    foreach (pr[i]) begin
      int idx = pr[i].y * W + pr[i].x;
      if (idx < got.size())
        chk($sformatf("%s_px_%0d_%0d", tag, pr[i].x, pr[i].y), 32'(got[idx].data), 32'(pr[i].exp));
      else
        chk($sformatf("%s_px_%0d_%0d_missing", tag, pr[i].x, pr[i].y), 32'(got.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    probe_t ov[];
    probe_t cl[];
    int fd_before;

    foreach (sh_m[i]) sh_m[i] = '{0, 0, 0, 0, 0, 16'h0};
    act_m = sh_m;

    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(axis_if.m_axis_tdata),  32'd0);
    chk("rst_tlast",  32'(axis_if.m_axis_tlast),  32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(frame_done), 32'd0);
    reset = 1'b0;
    tick();
    mon_en = 1;

    // Background-only frame with first-pixel latency
    start_frame();
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_tvalid_cycle1", 32'(axis_if.m_axis_tvalid), 32'd0);
    tick();
    chk("lat_tvalid_cycle2", 32'(axis_if.m_axis_tvalid), 32'd1);
    chk("lat_tdata_cycle2", 32'(axis_if.m_axis_tdata), 32'h0);
    finish_frame("bg");

    // Overlapping slots, lowest index wins
    write_slot(0, 10, 20, 5, 8, 16'hF800, 1, 0);
    write_slot(1, 15, 30, 0, 240, 16'h07E0, 1, 0);
    start_frame();
    finish_frame("overlap");
    ov = new[7];
    ov[0] = '{15, 5, 16'hF800};
    ov[1] = '{25, 5, 16'h07E0};
    ov[2] = '{9, 5, 16'h0000};
    ov[3] = '{20, 4, 16'h07E0};
    ov[4] = '{19, 7, 16'hF800};
    ov[5] = '{20, 8, 16'h07E0};
    ov[6] = '{30, 5, 16'h0000};
    run_probes("overlap", ov);

    // Random backpressure plus an ignored frame_start mid-frame
    bp_en = 1;
    start_frame();
    wait_pixels(100, "bp_mid");
    frame_start = 1'b1;
    tick();
    finish_frame("backpressure");
    bp_en = 0;
    fd_before = fd_cnt;
    repeat (10) tick();
    chk("no_queued_start_busy", 32'(busy), 32'd0);
    chk("no_queued_start_done", 32'(fd_cnt - fd_before), 32'd0);

    // Slot rewritten at the start edge and mid-frame: frame keeps old colour
    write_slot(0, 10, 20, 5, 8, 16'h001F, 1, 1);
    wait_pixels(1000, "rewrite_mid");
    write_slot(0, 10, 20, 5, 8, 16'h001F, 1, 0);
    finish_frame("old_color");
    chk("old_color_px_15_5", 32'(got[5 * W + 15].data), 32'hF800);
    start_frame();
    finish_frame("new_color");
    chk("new_color_px_15_5", 32'(got[5 * W + 15].data), 32'h001F);

    // Degenerate slot hidden, wide slot clipped at the right edge
    write_slot(0, 50, 50, 0, 48, 16'hABCD, 1, 0);
    write_slot(1, 40, 400, 10, 12, 16'h5555, 1, 0);
    write_slot(2, 0, 0, 0, 0, 16'h0, 0, 0);
    write_slot(3, 0, 0, 0, 0, 16'h0, 0, 0);
    start_frame();
    finish_frame("clip");
    cl = new[6];
    cl[0] = '{50, 10, 16'h5555};
    cl[1] = '{50, 20, 16'h0000};
    cl[2] = '{63, 10, 16'h5555};
    cl[3] = '{0, 11, 16'h0000};
    cl[4] = '{0, 12, 16'h0000};
    cl[5] = '{39, 11, 16'h0000};
    run_probes("clip", cl);

    // Randomized slots under random backpressure
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        if (s == 3)
          write_slot(s, $urandom_range(0, 511), $urandom_range(0, 511),
                     $urandom_range(0, 511), $urandom_range(0, 511),
                     16'($urandom), 1, 0);
        else
          write_slot(s, $urandom_range(0, 70), $urandom_range(0, 80),
                     $urandom_range(0, 50), $urandom_range(0, 60),
                     16'($urandom), 1'($urandom_range(0, 3) != 0), 0);
      end
      bp_en = 1;
      start_frame();
      finish_frame($sformatf("random%0d", f));
      bp_en = 0;
      repeat (2) tick();
    end

    // Reset mid-frame aborts without frame_done and clears slots
    write_slot(0, 0, 64, 0, 48, 16'h1234, 1, 0);
    start_frame();
    repeat (200) tick();
    frame_start = 1'b1;
    tick();
    wait_pixels(1000, "abort");
    fd_before = fd_cnt;
    reset = 1'b1;
    tick();
    chk("abort_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
    chk("abort_tdata",  32'(axis_if.m_axis_tdata),  32'd0);
    chk("abort_tlast",  32'(axis_if.m_axis_tlast),  32'd0);
    chk("abort_busy",   32'(busy), 32'd0);
    chk("abort_done",   32'(frame_done), 32'd0);
    foreach (sh_m[i]) sh_m[i] = '{0, 0, 0, 0, 0, 16'h0};
    act_m = sh_m;
    reset = 1'b0;
    repeat (20) tick();
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
    chk("abort_no_done", 32'(fd_cnt - fd_before), 32'd0);
    start_frame();
    finish_frame("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_rect_renderer.md
FRAME_RECT_RENDERER -- requirements
Module: frame_rect_renderer

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 320, giving pixels per line.
REQ-002 The block SHALL have parameter FRAME_H, default 240, giving lines per frame.
REQ-003 The block SHALL have parameter BG_COLOR, default 16'h0000, giving the RGB565 background colour.
REQ-004 The block SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port frame_start, input, 1 bit: pulse that requests one frame.
REQ-007 The block SHALL have port cfg_we, input, 1 bit: shadow rectangle write strobe.
REQ-008 The block SHALL have port cfg_idx, input, 2 bits: rectangle slot 0..3.
REQ-009 The block SHALL have ports cfg_x0, cfg_x1, cfg_y0 and cfg_y1, each input, 9 bits: inclusive start and exclusive end coordinates.
REQ-010 The block SHALL have port cfg_color, input, 16 bits: RGB565 fill colour.
REQ-011 The block SHALL have port cfg_en, input, 1 bit: slot enable.
REQ-012 The block SHALL have port busy, output, 1 bit: high while state is not IDLE.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel handshake.
REQ-014 The block SHALL have port m_axis_tvalid, output, 1 bit.
REQ-015 The block SHALL have port m_axis_tready, input, 1 bit.
REQ-016 The block SHALL have port m_axis_tlast, output, 1 bit: high on the final pixel of a frame only.
REQ-017 The block SHALL have port m_axis_tdata, output, 16 bits: RGB565 pixel.

Function
REQ-018 Write behaviour SHALL be: cfg_we=1 writes all cfg_* fields into shadow slot cfg_idx at the clock edge, in any state.
REQ-019 The state machine SHALL have states IDLE, RUN and DRAIN.
REQ-020 In IDLE, frame_start=1 SHALL, at that edge, copy all shadow slots to active slots, clear x and y to 0, and enter RUN.
REQ-021 A shadow write at the same edge as the copy SHALL be excluded from the copy; the copy uses the pre-write shadow value.
REQ-022 frame_start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-023 In RUN, the block SHALL register one pixel whenever m_axis_tvalid=0 or m_axis_tready=1, setting tdata=colour(x,y), tvalid=1 and tlast=(x==FRAME_W-1 && y==FRAME_H-1).
REQ-024 On each pixel registered under REQ-023, x SHALL increment, wrapping to 0 at FRAME_W-1 and incrementing y; after the last pixel the state SHALL become DRAIN.
REQ-025 Latency SHALL be: first pixel tvalid high in the second cycle after the frame_start edge (one cycle in RUN before the first register).
REQ-026 With m_axis_tready held at 1, the block SHALL deliver one pixel per cycle with no bubbles.
REQ-027 While tvalid=1 and tready=0, tdata, tlast and tvalid SHALL hold stable, and x and y SHALL not advance.
REQ-028 In DRAIN, when tvalid && tready, the block SHALL clear tvalid and tlast, pulse frame_done for that one cycle, and return to IDLE.
REQ-029 A frame_start at the IDLE edge immediately after DRAIN SHALL be accepted normally.
REQ-030 colour(x,y) SHALL be cfg_color of the lowest-index active slot satisfying en && x0<=x<x1 && y0<=y<y1, using unsigned 9-bit compares; otherwise BG_COLOR.
REQ-031 A slot with x1<=x0 or y1<=y0 SHALL match no pixel; coordinates beyond frame bounds SHALL simply clip.
REQ-032 Active slots SHALL be constant for the whole frame.
REQ-033 Exactly FRAME_W*FRAME_H handshakes SHALL occur per frame, with exactly one tlast.

Reset
REQ-034 On reset=1 at an edge, the block SHALL enter IDLE with m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0, frame_done=0 and x=y=0.
REQ-035 On reset=1 at an edge, all shadow and active slots SHALL be cleared (en=0, coordinates 0, colour 0).
REQ-036 Reset SHALL dominate all other inputs, including mid-frame, where it aborts the frame with no frame_done.
REQ-037 After reset deasserts, the block SHALL resume only on a new frame_start.

Verification
REQ-038 Test: reset, then frame_start with tready=1 and no slots enabled -> 76800 pixels of 16'h0000, tlast only on pixel 76799, frame_done one cycle after it.
REQ-039 Test: slot0 {x 10..20, y 5..8, F800, en}, slot1 {x 15..30, y 0..240, 07E0, en} -> pixel (15,5)=F800, (25,5)=07E0, (9,5)=0000, (20,4)=07E0.
REQ-040 Test: random tready backpressure -> tdata and tlast stable while stalled, pixel sequence identical to the tready=1 run, 76800 handshakes.
REQ-041 Test: a slot rewritten to colour 001F at the frame_start edge, and again mid-frame -> entire frame uses the old colour; the next frame uses 001F.
REQ-042 Test: frame_start pulsed during RUN, and reset asserted at pixel 1000 -> frame_start ignored; outputs cleared the next cycle, busy=0, no frame_done.
REQ-043 Test: degenerate slot x0=50, x1=50, and a slot with x1=400 -> degenerate slot never shown; wide slot clipped at x=319 with no wrap.
